dsp_preadd_mult: RTL
====================

# dsp_preadd_mult

Pre-adder and multiplier stage of the DSP48A1 slice datapath. Consumes the registered 18-bit A0/B0 operand outputs and the D operand of the input register stage. Forms the optionally pre-added B operand and the signed 18×18 product. Provides independently enabled, optionally bypassed stage-1 (A1/B1) and M pipeline registers, with a valid tag that travels alongside the data.

## Interface
- REG1, default 1: 1 = stage-1 A1/B1 registers present; 0 = combinational bypass
- MREG, default 1: 1 = product register present; 0 = combinational bypass
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset; clears every register in the block
- CE1  in  1  clock enable for stage-1 registers and stage-1 valid tag
- CEM  in  1  clock enable for M register and M valid tag
- A  in  18  signed multiplier operand (from A0 register stage)
- B  in  18  signed B operand (from B0 register stage)
- D  in  18  signed pre-adder operand (from D register stage)
- OPMODE  in  2  bit[1] = pre-add/sub select (0 add, 1 subtract D−B); bit[0] = pre-adder use (1 use pre-adder result, 0 pass B)
- in_valid  in  1  marks A/B/D/OPMODE as a live sample
- BCOUT  out  18  stage-1 B1 value (cascade output)
- M  out  36  signed product A1×B1
- out_valid  out  1  valid tag aligned with M

## Operation
- Pre-adder: PRE = OPMODE[1] ? (D − B) : (D + B), 18-bit two's complement, wraps modulo 2^18, carry/borrow discarded.
- B1_next = OPMODE[0] ? PRE : B; A1_next = A.
- Stage 1 (REG1=1): on rising CLK with CE1=1, A1←A1_next, B1←B1_next, V1←in_valid. With CE1=0, all three hold.
- Stage 1 (REG1=0): A1/B1/V1 follow their inputs combinationally; CE1 is ignored.
- Product: M_next = signed(A1) × signed(B1), full 36-bit result with no truncation or saturation.
- Stage 2 (MREG=1): on rising CLK with CEM=1, M←M_next and V2←V1. With CEM=0, both hold.
- Stage 2 (MREG=0): M/V2 follow combinationally; CEM is ignored.
- BCOUT = B1 and out_valid = V2.
- Valid tags carry no back-pressure. Data moves only under CE, and a tag moves only with its own stage's data.
- Reset: RST low asynchronously forces A1, B1, M, V1, V2 to 0, so BCOUT=0, M=0, out_valid=0. With both registers bypassed, outputs are purely combinational and reset has no effect.
- Reset mid-operation: in-flight samples are discarded. The first sample after RST returns high appears with full latency.
- Simultaneous CE1=1, CEM=1: stage 2 captures the old stage-1 content while stage 1 captures new input, giving standard pipeline advance.
- CE1=1, CEM=0: stage 1 overwrites, and its previous content is lost if CEM was not asserted. This is intended DSP48A1 behaviour and must not be blocked.

## Timing
- Latency from A/B/D/in_valid to M/out_valid is REG1+MREG cycles, given CE asserted on each of those edges.
- Latency from input to BCOUT is REG1 cycles.
- Reset assertion takes effect with no clock. Deassertion is sampled synchronously by the first CLK edge after release.
- OPMODE is sampled in the same cycle as its operands. It is not pipelined separately.

## Structure
- Shared package dsp48a1_pkg:
  - widths A_W=18, B_W=18, D_W=18, M_W=36
  - OPMODE bit-index constants OP_PREADD_SUB=1, OP_PREADD_EN=0
- Sub-module dsp_pipe_reg, parameters WIDTH and REG, with CLK, CE and active-low async RST:
  - one optional register with bypass mux
  - instantiated for A1, B1, V1 (REG=REG1) and for M, V2 (REG=MREG)
- Pre-adder and multiplier stay inline.

## Test plan
- Add, defaults: A=3, B=30, D=100, OPMODE=2'b01, in_valid=1, CE1=CEM=1.
  - Cycle 1: BCOUT=130.
  - Cycle 2: M=390, out_valid=1.
- Subtract with negatives: A=−5, B=30, D=10, OPMODE=2'b11.
  - BCOUT=0x3FFEC (−20).
  - M=100 after 2 cycles.
- Wrap and bypass:
  - D=0x1FFFF, B=1, OPMODE=2'b01, A=2 → BCOUT=0x20000 (−131072), M=−262144.
  - Then OPMODE=2'b00, B=7 → BCOUT=7 and M=14 after 2 cycles.
- Enables:
  - Load A=4, B=5, OPMODE=00, then drop CEM for 3 cycles while feeding A=9, B=9 → M holds its prior value.
  - Raise CEM → M=81 on the next edge. The 4×5 sample is lost, as intended.
- Reset mid-flight: pull RST low between edges while M=390 and out_valid=1.
  - M, BCOUT and out_valid go to 0 immediately, with no clock.
  - After release, a new sample A=2, B=3 gives M=6 exactly 2 cycles later.
- Parameter sweep: REG1=0/MREG=0 → M=A×B in the same cycle. REG1=1/MREG=0 and REG1=0/MREG=1 → latency 1. Repeat the add vector in each configuration.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// -----------------------------------------------------------------------------
// dsp48a1_pkg
// Shared widths, OPMODE bit positions and the pre-adder helper for the
// DSP48A1 datapath blocks.
//   A_W/B_W/D_W : operand widths (18)
//   M_W         : full signed product width (36)
//   OP_*        : OPMODE bit indices
// -----------------------------------------------------------------------------
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int D_W = 18;
  localparam int M_W = 36;

  localparam int OP_PREADD_SUB = 1;  // 0: D+B, 1: D-B
  localparam int OP_PREADD_EN  = 0;  // 1: feed pre-adder result, 0: pass B

  // 18-bit two's-complement pre-adder; carry/borrow out is simply dropped.
  function automatic logic [B_W-1:0] preadd(
    input logic [D_W-1:0] d,
    input logic [B_W-1:0] b,
    input logic           sub
  );
    logic [B_W-1:0] r;
    if (sub) begin
      r = d - b;
    end else begin
      r = d + b;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_preadd_mult_if.sv
// -----------------------------------------------------------------------------
// dsp_preadd_mult_if
// Operand/result bundle of the pre-adder/multiplier stage.
//   master : drives CE1, CEM, A, B, D, OPMODE, in_valid; observes results
//   slave  : the datapath; consumes operands, drives BCOUT, M, out_valid
// -----------------------------------------------------------------------------
interface dsp_preadd_mult_if;
  import dsp48a1_pkg::*;

  logic           CE1;
  logic           CEM;
  logic [A_W-1:0] A;
  logic [B_W-1:0] B;
  logic [D_W-1:0] D;
  logic [1:0]     OPMODE;
  logic           in_valid;
  logic [B_W-1:0] BCOUT;
  logic [M_W-1:0] M;
  logic           out_valid;

  modport master (
    output CE1, CEM, A, B, D, OPMODE, in_valid,
    input  BCOUT, M, out_valid
  );

  modport slave (
    input  CE1, CEM, A, B, D, OPMODE, in_valid,
    output BCOUT, M, out_valid
  );

endinterface

// File: rtl/dsp_pipe_reg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_reg
// One optional pipeline register with clock enable. REG=1 gives a register
// cleared by the async active-low RST; REG=0 is a plain wire and ignores
// CLK/CE/RST.
//   CLK  : rising-edge clock
//   RST  : async active-low reset
//   CE   : capture enable
//   d_i  : next value
//   q_o  : registered (or bypassed) value
// -----------------------------------------------------------------------------
module dsp_pipe_reg #(
  parameter int WIDTH = 1,
  parameter bit REG   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (REG) begin : g_reg
      logic [WIDTH-1:0] data_q;

      // Enabled capture; holds when CE is low.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          data_q <= '0;
        end else if (CE) begin
          data_q <= d_i;
        end else begin
          data_q <= data_q;
        end
      end

      assign q_o = data_q;
    end else begin : g_bypass
      // Clock, enable and reset have no role in the bypassed form.
      logic unused_ctrl_s;
      assign unused_ctrl_s = CLK ^ RST ^ CE;
      assign q_o = d_i;
    end
  endgenerate

endmodule

// File: rtl/dsp_preadd_mult.sv
// -----------------------------------------------------------------------------
// dsp_preadd_mult
// Pre-adder + signed 18x18 multiplier stage of the DSP48A1 slice with
// optional stage-1 (A1/B1) and M registers, each carrying a valid tag.
//   CLK        : rising-edge clock
//   RST        : async active-low reset, clears all registers
//   bus.CE1    : enable for A1/B1/V1
//   bus.CEM    : enable for M/V2
//   bus.A/B/D  : signed 18-bit operands
//   bus.OPMODE : [1] pre-add subtract, [0] use pre-adder result
//   bus.in_valid  : sample tag in
//   bus.BCOUT  : B1 cascade output
//   bus.M      : 36-bit signed product A1*B1
//   bus.out_valid : tag aligned with M
// -----------------------------------------------------------------------------
module dsp_preadd_mult #(
  parameter bit REG1 = 1'b1,
  parameter bit MREG = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  dsp_preadd_mult_if.slave  bus
);
  import dsp48a1_pkg::*;

  logic [B_W-1:0] pre_s;
  logic [B_W-1:0] b1_d;
  logic [A_W-1:0] a1_q;
  logic [B_W-1:0] b1_q;
  logic           v1_q;
  logic [M_W-1:0] m_d;
  logic [M_W-1:0] m_q;
  logic           v2_q;

  // Pre-adder and B1 operand select; OPMODE travels with its own operands.
  always_comb begin
    pre_s = preadd(bus.D, bus.B, bus.OPMODE[OP_PREADD_SUB]);
    if (bus.OPMODE[OP_PREADD_EN]) begin
      b1_d = pre_s;
    end else begin
      b1_d = bus.B;
    end
  end

  dsp_pipe_reg #(.WIDTH(A_W), .REG(REG1)) u_a1 (
    .CLK(CLK), .RST(RST), .CE(bus.CE1), .d_i(bus.A), .q_o(a1_q)
  );

  dsp_pipe_reg #(.WIDTH(B_W), .REG(REG1)) u_b1 (
    .CLK(CLK), .RST(RST), .CE(bus.CE1), .d_i(b1_d), .q_o(b1_q)
  );

  dsp_pipe_reg #(.WIDTH(1), .REG(REG1)) u_v1 (
    .CLK(CLK), .RST(RST), .CE(bus.CE1), .d_i(bus.in_valid), .q_o(v1_q)
  );

  // Full-precision signed product; both operands sign-extend to 36 bits.
  always_comb begin
    m_d = $signed(a1_q) * $signed(b1_q);
  end

  dsp_pipe_reg #(.WIDTH(M_W), .REG(MREG)) u_m (
    .CLK(CLK), .RST(RST), .CE(bus.CEM), .d_i(m_d), .q_o(m_q)
  );

  dsp_pipe_reg #(.WIDTH(1), .REG(MREG)) u_v2 (
    .CLK(CLK), .RST(RST), .CE(bus.CEM), .d_i(v1_q), .q_o(v2_q)
  );

  assign bus.BCOUT     = b1_q;
  assign bus.M         = m_q;
  assign bus.out_valid = v2_q;

endmodule
